// File: rtl/dct_row_loader.sv
// Row loader for the 8-point DCT stage: packs 8 pixels per row into ping-pong
// buffers (fill + present) and hands rows downstream with block position tags.
module dct_row_loader #(
  parameter int unsigned ROWS_PER_BLOCK = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] x0,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [7:0] x5,
  output logic [7:0] x6,
  output logic [7:0] x7,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [7:0] row_idx,
  output logic       block_start,
  output logic       block_end
);

  localparam int unsigned PW   = 8;
  localparam int unsigned NPIX = 8;
  localparam int unsigned ROWW = PW * NPIX;
  localparam int unsigned COLW = 3;
  localparam int unsigned IDXW = 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ROWS_PER_BLOCK - 1);
  localparam logic [COLW-1:0] LAST_COL = COLW'(NPIX - 1);

  logic [ROWW-1:0] fill_q, fill_n, pres_q, pres_n, merged;
  logic            fill_full_q, fill_full_n;
  logic            valid_n;
  logic [COLW-1:0] col_q, col_n;
  logic [IDXW-1:0] idx_n;
  logic            accept, consume;

  // Next-state: consume frees the present side first, then a completed row
  // either goes straight to the present side or parks in the fill buffer.
  always_comb begin
    accept      = pix_valid && pix_ready;
    consume     = row_valid && row_ready;
    merged      = fill_q;
    merged[32'(col_q) * PW +: PW] = pix_in;
    fill_n      = fill_q;
    fill_full_n = fill_full_q;
    pres_n      = pres_q;
    valid_n     = row_valid;
    col_n       = col_q;
    idx_n       = row_idx;

    if (consume) begin
      idx_n   = (row_idx == LAST_IDX) ? '0 : row_idx + IDXW'(1);
      valid_n = 1'b0;
      if (fill_full_q) begin
        pres_n      = fill_q;
        valid_n     = 1'b1;
        fill_full_n = 1'b0;
      end
    end

    if (accept) begin
      col_n  = col_q + COLW'(1);
      fill_n = merged;
      if (col_q == LAST_COL) begin
        if (!valid_n) begin
          pres_n  = merged;
          valid_n = 1'b1;
        end else begin
          fill_full_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= '0;
      pres_q      <= '0;
      fill_full_q <= 1'b0;
      col_q       <= '0;
      row_valid   <= 1'b0;
      row_idx     <= '0;
      pix_ready   <= 1'b1;
      block_start <= 1'b0;
      block_end   <= 1'b0;
    end else begin
      fill_q      <= fill_n;
      pres_q      <= pres_n;
      fill_full_q <= fill_full_n;
      col_q       <= col_n;
      row_valid   <= valid_n;
      row_idx     <= idx_n;
      pix_ready   <= !fill_full_n;
      block_start <= valid_n && (idx_n == '0);
      block_end   <= valid_n && (idx_n == LAST_IDX);
    end
  end

  assign x0 = pres_q[0*PW +: PW];
  assign x1 = pres_q[1*PW +: PW];
  assign x2 = pres_q[2*PW +: PW];
  assign x3 = pres_q[3*PW +: PW];
  assign x4 = pres_q[4*PW +: PW];
  assign x5 = pres_q[5*PW +: PW];
  assign x6 = pres_q[6*PW +: PW];
  assign x7 = pres_q[7*PW +: PW];

endmodule

// File: tb/tb_dct_row_loader.sv
// Directed + scoreboard bench for dct_row_loader; a second instance with
// two rows per block shares the stimulus to exercise block tag wrapping.
module tb_dct_row_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_in = '0;
  logic       pix_valid = 1'b0;
  logic       row_ready = 1'b0;

  logic       pix_ready, row_valid, block_start, block_end;
  logic [7:0] row_idx;
  logic [7:0] x[8];
  logic       pix_ready2, row_valid2, block_start2, block_end2;
  logic [7:0] row_idx2;
  logic [7:0] y[8];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q[$];
  int exp_idx = 0;
  int exp_idx2 = 0;
  int rows_seen = 0;

  always #5 clk = ~clk;

  dct_row_loader #(.ROWS_PER_BLOCK(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
    .block_start(block_start), .block_end(block_end));

  dct_row_loader #(.ROWS_PER_BLOCK(2)) dut2 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready2),
    .x0(y[0]), .x1(y[1]), .x2(y[2]), .x3(y[3]), .x4(y[4]), .x5(y[5]), .x6(y[6]), .x7(y[7]),
    .row_valid(row_valid2), .row_ready(row_ready), .row_idx(row_idx2),
    .block_start(block_start2), .block_end(block_end2));

  function automatic logic [63:0] cur_row();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = x[k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One cycle: apply inputs, score the handshakes that fire on the next edge.
  task automatic step(input logic pv, input logic [7:0] pix, input logic rr);
    logic [63:0] expr;
    pix_valid = pv;
    pix_in    = pix;
    row_ready = rr;
    if (row_valid && rr) begin
      expr = '0;
      if (q.size() < 8) chk("sb_underflow", 64'(q.size()), 64'd8);
      for (int k = 0; k < 8; k++) if (q.size() > 0) expr[k*8 +: 8] = q.pop_front();
      chk("sb_row", cur_row(), expr);
      chk("sb_idx", 64'(row_idx), 64'(exp_idx));
      chk("sb_bs", 64'(block_start), 64'(exp_idx == 0));
      chk("sb_be", 64'(block_end), 64'(exp_idx == 7));
      exp_idx = (exp_idx == 7) ? 0 : exp_idx + 1;
      rows_seen++;
    end
    if (row_valid2 && rr) begin
      chk("sb2_idx", 64'(row_idx2), 64'(exp_idx2));
      chk("sb2_bs", 64'(block_start2), 64'(exp_idx2 == 0));
      chk("sb2_be", 64'(block_end2), 64'(exp_idx2 == 1));
      exp_idx2 = (exp_idx2 == 1) ? 0 : 1;
    end
    if (pv && pix_ready) q.push_back(pix);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    row_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_idx = 0;
    exp_idx2 = 0;
    chk("rst_pix_ready", 64'(pix_ready), 64'd1);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_row", cur_row(), 64'd0);
    chk("rst_idx", 64'(row_idx), 64'd0);
    chk("rst_bs_be", 64'({block_start, block_end}), 64'd0);
    chk("rst2_row_valid", 64'(row_valid2), 64'd0);
  endtask

  typedef struct {
    logic       pv;
    logic [7:0] pix;
    logic       rr;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_x0;
    logic [7:0] e_x7;
    logic [7:0] e_idx;
    logic       e_bs;
    logic       e_be;
  } vec_t;

  initial begin
    vec_t vt[10];
    int p, guard, low_cnt, acc;
    logic [63:0] row0;

    // Basic row assembly then consume, values after each edge.
    for (int i = 0; i < 7; i++)
      vt[i] = '{1'b1, 8'(10 * (i + 1)), 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'd80, 1'b1, 1'b1, 1'b1, 8'd10, 8'd80, 8'd0, 1'b1, 1'b0};
    vt[8] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd10, 8'd80, 8'd0, 1'b1, 1'b0};
    vt[9] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd10, 8'd80, 8'd1, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vt[i].pv, vt[i].pix, vt[i].rr);
      chk($sformatf("v%0d_ready", i), 64'(pix_ready), 64'(vt[i].e_ready));
      chk($sformatf("v%0d_valid", i), 64'(row_valid), 64'(vt[i].e_valid));
      chk($sformatf("v%0d_x0", i), 64'(x[0]), 64'(vt[i].e_x0));
      chk($sformatf("v%0d_x7", i), 64'(x[7]), 64'(vt[i].e_x7));
      chk($sformatf("v%0d_idx", i), 64'(row_idx), 64'(vt[i].e_idx));
      chk($sformatf("v%0d_bs", i), 64'(block_start), 64'(vt[i].e_bs));
      chk($sformatf("v%0d_be", i), 64'(block_end), 64'(vt[i].e_be));
    end
    chk("v_rows", 64'(rows_seen), 64'd1);

    // Back-pressure: 24 pixels with no consumer.
    do_reset();
    rows_seen = 0;
    p = 1;
    guard = 0;
    while (p <= 16 && guard < 40) begin
      acc = pix_ready;
      step(1'b1, 8'(p), 1'b0);
      if (acc != 0) p++;
      guard++;
    end
    chk("bp_accepted16", 64'(p), 64'd17);
    chk("bp_ready_low", 64'(pix_ready), 64'd0);
    for (int k = 0; k < 8; k++) row0[k*8 +: 8] = 8'(k + 1);
    repeat (3) step(1'b1, 8'(p), 1'b0);
    chk("bp_row0_held", cur_row(), row0);
    chk("bp_ready_still_low", 64'(pix_ready), 64'd0);
    step(1'b1, 8'(p), 1'b1);
    chk("bp_ready_back", 64'(pix_ready), 64'd1);
    chk("bp_row1_idx", 64'(row_idx), 64'd1);
    guard = 0;
    while (p <= 24 && guard < 40) begin
      acc = pix_ready;
      step(1'b1, 8'(p), 1'b0);
      if (acc != 0) p++;
      guard++;
    end
    chk("bp_accepted24", 64'(p), 64'd25);
    repeat (4) step(1'b0, 8'd0, 1'b1);
    chk("bp_rows", 64'(rows_seen), 64'd3);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // Full rate with consumer always ready.
    do_reset();
    rows_seen = 0;
    low_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (!pix_ready) low_cnt++;
      step(1'b1, 8'(i + 100), 1'b1);
    end
    step(1'b0, 8'd0, 1'b1);
    chk("rate_ready_lows", 64'(low_cnt), 64'd0);
    chk("rate_rows", 64'(rows_seen), 64'd8);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 50), 1'b0);
    chk("rate_wrap_valid", 64'(row_valid), 64'd1);
    chk("rate_wrap_idx", 64'(row_idx), 64'd0);
    chk("rate_wrap_bs", 64'(block_start), 64'd1);
    chk("rate_wrap_x0", 64'(x[0]), 64'd50);

    // Reset mid-row with an unconsumed row still presented.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 1), 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(200 + i), 1'b0);
    chk("rst_next_valid", 64'(row_valid), 64'd1);
    chk("rst_next_x0", 64'(x[0]), 64'd200);
    chk("rst_next_x7", 64'(x[7]), 64'd207);
    step(1'b0, 8'd0, 1'b1);

    // Random handshakes, 10k pixels scored in order.
    do_reset();
    rows_seen = 0;
    p = 0;
    guard = 0;
    while (p < 10000 && guard < 80000) begin
      logic pv, rr;
      pv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      acc = pv && pix_ready;
      step(pv, 8'($urandom), rr);
      if (acc != 0) p++;
      guard++;
    end
    chk("rand_pixels", 64'(p), 64'd10000);
    repeat (4) step(1'b0, 8'd0, 1'b1);
    chk("rand_rows", 64'(rows_seen), 64'd1250);
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
